// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: op classes, funct3 codes,
// FSM state encodings and bus widths.
package mem_access_unit_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;
  localparam int MEM_SEL_W  = 4;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'h00;
  localparam logic [ALUOP_W-1:0] EXE_LOAD_OP  = 8'h01;
  localparam logic [ALUOP_W-1:0] EXE_STORE_OP = 8'h02;
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP   = 8'h10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS1 = 2'd1,
    ST_BUS2 = 2'd2,
    ST_DONE = 2'd3
  } mau_state_e;

  // Unshifted byte-lane mask for the access size held in funct3[1:0].
  function automatic logic [MEM_SEL_W-1:0] size_mask(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load formatter: picks the addressed byte/half/word out of the read data and
// sign- or zero-extends it. The input is a 64-bit pair {upper word, lower word}
// so a word-crossing access (split build) is handled by the same shift.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [2*XLEN-1:0] rdata_i,
  input  logic [1:0]        offset_i,
  input  logic [2:0]        funct3_i,
  output logic [XLEN-1:0]   data_o
);

  logic [XLEN-1:0] word;

  // Shift the addressed byte down to lane 0, then extend per funct3.
  always_comb begin
    word = XLEN'(rdata_i >> {offset_i, 3'b000});
    case (funct3_i)
      F3_LB:   data_o = {{24{word[7]}}, word[7:0]};
      F3_LH:   data_o = {{16{word[15]}}, word[15:0]};
      F3_LW:   data_o = word;
      F3_LBU:  data_o = {24'h0, word[7:0]};
      F3_LHU:  data_o = {16'h0, word[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns ex_mem load/store ops into single-word bus
// transactions and stalls the pipeline while one is outstanding.
// Build option: MISALIGN_SPLIT_EN splits word-crossing accesses into two
// transactions; without it misaligned accesses are rejected with misalign_o.
//
// state | meaning
// IDLE  | pass-through; memory op seen -> stall and launch
// BUS1  | first (or only) request outstanding
// BUS2  | second half of a split access (MISALIGN_SPLIT_EN only)
// DONE  | result presented to mem_wb; held while hold_i
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [XLEN-1:0]       wdata_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [2:0]            alufun3_i,
  input  logic [XLEN-1:0]       mem_addr_i,
  input  logic [XLEN-1:0]       reg2_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic                  stallreq_o,
  output logic                  dbus_req_o,
  output logic                  dbus_we_o,
  output logic [XLEN-1:0]       dbus_addr_o,
  output logic [MEM_SEL_W-1:0]  dbus_be_o,
  output logic [XLEN-1:0]       dbus_wdata_o,
  input  logic                  dbus_ack_i,
  input  logic [XLEN-1:0]       dbus_rdata_i,
  output logic                  misalign_o
);

  mau_state_e           state_q, state_d;
  logic                 dbus_req_q, dbus_req_d;
  logic                 dbus_we_q, dbus_we_d;
  logic [XLEN-1:0]      dbus_addr_q, dbus_addr_d;
  logic [MEM_SEL_W-1:0] dbus_be_q, dbus_be_d;
  logic [XLEN-1:0]      dbus_wdata_q, dbus_wdata_d;
  logic                 misalign_q, misalign_d;
  logic [XLEN-1:0]      rdata_lo_q, rdata_lo_d;

  logic                 is_load, is_store, is_mem, f3_ok, misal, reject;
  logic [MEM_SEL_W-1:0] mask, be_lo;
  logic [XLEN-1:0]      wdata_rep, wd_lo, load_val;
  logic [2*XLEN-1:0]    align_in;

`ifdef MISALIGN_SPLIT_EN
  logic [XLEN-1:0]      rdata_hi_q, rdata_hi_d;
  logic                 cross;
  logic [7:0]           be_pair;
  logic [2*XLEN-1:0]    st_pair;
`endif

  // Decode the op: validity, alignment, lane mask and store data placement.
  always_comb begin
    is_load   = (aluop_i == EXE_LOAD_OP);
    is_store  = (aluop_i == EXE_STORE_OP);
    is_mem    = is_load || is_store;
    f3_ok     = is_store ? (!alufun3_i[2] && alufun3_i[1:0] != 2'b11)
                         : (alufun3_i[1:0] != 2'b11 && !(alufun3_i[2] && alufun3_i[1]));
    misal     = f3_ok && ((alufun3_i[1:0] == 2'b01 && mem_addr_i[0]) ||
                          (alufun3_i[1:0] == 2'b10 && mem_addr_i[1:0] != 2'b00));
    mask      = size_mask(alufun3_i[1:0]);
    case (alufun3_i[1:0])
      2'b00:   wdata_rep = {4{reg2_i[7:0]}};
      2'b01:   wdata_rep = {2{reg2_i[15:0]}};
      default: wdata_rep = reg2_i;
    endcase
`ifdef MISALIGN_SPLIT_EN
    cross     = misal && (alufun3_i[1:0] == 2'b10 || mem_addr_i[1:0] == 2'b11);
    be_pair   = {4'b0000, mask} << mem_addr_i[1:0];
    be_lo     = be_pair[3:0];
    st_pair   = {32'h0, reg2_i} << {mem_addr_i[1:0], 3'b000};
    // Replication cannot place a word-crossing store; use the true byte shift.
    wd_lo     = cross ? st_pair[XLEN-1:0] : wdata_rep;
    reject    = !f3_ok;
    align_in  = {rdata_hi_q, rdata_lo_q};
`else
    be_lo     = mask << mem_addr_i[1:0];
    wd_lo     = wdata_rep;
    reject    = !f3_ok || misal;
    align_in  = {32'h0, rdata_lo_q};
`endif
  end

  mem_load_align u_load_align (
    .rdata_i  (align_in),
    .offset_i (mem_addr_i[1:0]),
    .funct3_i (alufun3_i),
    .data_o   (load_val)
  );

  // Next-state, bus register loads and mem_wb output mux.
  always_comb begin
    state_d      = state_q;
    dbus_req_d   = dbus_req_q;
    dbus_we_d    = dbus_we_q;
    dbus_addr_d  = dbus_addr_q;
    dbus_be_d    = dbus_be_q;
    dbus_wdata_d = dbus_wdata_q;
    misalign_d   = 1'b0;
    rdata_lo_d   = rdata_lo_q;
`ifdef MISALIGN_SPLIT_EN
    rdata_hi_d   = rdata_hi_q;
`endif
    stallreq_o   = 1'b0;
    wd_o         = wd_i;
    wreg_o       = wreg_i;
    wdata_o      = wdata_i;
    case (state_q)
      ST_IDLE: begin
        if (is_mem) begin
          stallreq_o = 1'b1;
          wreg_o     = 1'b0;
          if (reject) begin
            state_d    = ST_DONE;
            misalign_d = misal;
          end else begin
            state_d      = ST_BUS1;
            dbus_req_d   = 1'b1;
            dbus_we_d    = is_store;
            dbus_addr_d  = {mem_addr_i[XLEN-1:2], 2'b00};
            dbus_be_d    = be_lo;
            dbus_wdata_d = wd_lo;
          end
        end
      end
      ST_BUS1: begin
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        if (dbus_ack_i) begin
          rdata_lo_d = dbus_rdata_i;
`ifdef MISALIGN_SPLIT_EN
          if (cross) begin
            // Second half goes out straight away at the next word.
            state_d      = ST_BUS2;
            dbus_addr_d  = dbus_addr_q + 32'd4;
            dbus_be_d    = be_pair[7:4];
            dbus_wdata_d = st_pair[2*XLEN-1:XLEN];
          end else
`endif
          begin
            state_d    = ST_DONE;
            dbus_req_d = 1'b0;
          end
        end
      end
`ifdef MISALIGN_SPLIT_EN
      ST_BUS2: begin
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        if (dbus_ack_i) begin
          rdata_hi_d = dbus_rdata_i;
          state_d    = ST_DONE;
          dbus_req_d = 1'b0;
        end
      end
`endif
      ST_DONE: begin
        wdata_o = reject ? '0 : load_val;
        wreg_o  = (is_load && !reject) ? wreg_i : 1'b0;
        if (!hold_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      wd_o    = '0;
      wreg_o  = 1'b0;
      wdata_o = '0;
    end
  end

  // State and bus registers; reset drops any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_be_q    <= '0;
      dbus_wdata_q <= '0;
      misalign_q   <= 1'b0;
      rdata_lo_q   <= '0;
`ifdef MISALIGN_SPLIT_EN
      rdata_hi_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dbus_req_q   <= dbus_req_d;
      dbus_we_q    <= dbus_we_d;
      dbus_addr_q  <= dbus_addr_d;
      dbus_be_q    <= dbus_be_d;
      dbus_wdata_q <= dbus_wdata_d;
      misalign_q   <= misalign_d;
      rdata_lo_q   <= rdata_lo_d;
`ifdef MISALIGN_SPLIT_EN
      rdata_hi_q   <= rdata_hi_d;
`endif
    end
  end

  assign dbus_req_o   = dbus_req_q;
  assign dbus_we_o    = dbus_we_q;
  assign dbus_addr_o  = dbus_addr_q;
  assign dbus_be_o    = dbus_be_q;
  assign dbus_wdata_o = dbus_wdata_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a bus-slave driver task collects what the DUT
// does; each scenario task pushes its expectations to scoreboard queues and
// compares them against the collected observations.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, hold_i, wreg_i, dbus_ack_i;
  logic [4:0]  wd_i;
  logic [31:0] wdata_i, mem_addr_i, reg2_i, dbus_rdata_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alufun3_i;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq_o, dbus_req_o, dbus_we_o, misalign_o;
  logic [31:0] wdata_o, dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .hold_i(hold_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .aluop_i(aluop_i), .alufun3_i(alufun3_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stallreq_o(stallreq_o), .dbus_req_o(dbus_req_o),
    .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i),
    .dbus_rdata_i(dbus_rdata_i), .misalign_o(misalign_o)
  );

  typedef struct {logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;} bus_exp_t;
  typedef struct {logic [31:0] wdata; logic wreg; logic misal; logic chk_wd; int stall;} res_exp_t;
  typedef struct {
    logic [7:0] op; logic [2:0] f3; logic [31:0] addr, reg2; int waits; logic [31:0] rd;
    int nbus; logic [31:0] baddr; logic [3:0] be; logic we; logic [31:0] bwd;
    logic [31:0] rwd; logic rwreg; logic chk; int stall;
  } tbl_t;

  bus_exp_t exp_bus_q[$];
  res_exp_t exp_res_q[$];
  int vectors = 0, miscompares = 0;

  int          obs_n, obs_stall;
  logic        obs_timeout, obs_held_ok, obs_res_req, obs_wreg, obs_misal;
  logic [4:0]  obs_wd;
  logic [31:0] obs_wdata_o;
  logic [31:0] obs_addr[2], obs_wdata[2];
  logic [3:0]  obs_be[2];
  logic        obs_we[2];

  task automatic set_nop();
    aluop_i = EXE_ADD_OP; alufun3_i = 3'b000; mem_addr_i = 32'h0; reg2_i = 32'h0;
    wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
  endtask

  // Present one op (called just after a rising edge), play bus slave, collect.
  task automatic run_mem(input logic [7:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] reg2, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] alu, input int waits, input logic [31:0] rd0,
                         input logic [31:0] rd1, input int hold_cyc);
    int wcnt = 0;
    aluop_i = op; alufun3_i = f3; mem_addr_i = addr; reg2_i = reg2;
    wd_i = wd; wreg_i = wreg; wdata_i = alu;
    obs_n = 0; obs_stall = 0; obs_timeout = 1'b1; obs_held_ok = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (!stallreq_o) begin
        obs_timeout = 1'b0;
        obs_wdata_o = wdata_o; obs_wreg = wreg_o; obs_misal = misalign_o;
        obs_wd = wd_o; obs_res_req = dbus_req_o;
        for (int h = 0; h < hold_cyc; h++) begin
          hold_i = 1'b1;
          @(negedge clk);
          if (stallreq_o || wdata_o !== obs_wdata_o || wreg_o !== obs_wreg) obs_held_ok = 1'b0;
        end
        hold_i = 1'b0;
        @(posedge clk); #1;
        break;
      end
      obs_stall++;
      if (dbus_req_o) begin
        if (wcnt == 0 && obs_n < 2) begin
          obs_addr[obs_n] = dbus_addr_o; obs_be[obs_n] = dbus_be_o;
          obs_we[obs_n] = dbus_we_o; obs_wdata[obs_n] = dbus_wdata_o;
        end
        if (wcnt == waits) begin
          dbus_ack_i = 1'b1; dbus_rdata_i = (obs_n == 0) ? rd0 : rd1;
          obs_n++; wcnt = 0;
        end else wcnt++;
      end
      @(posedge clk); #1;
      dbus_ack_i = 1'b0; dbus_rdata_i = $urandom;
    end
    set_nop();
  endtask

  task automatic test_reset();
    bus_exp_t be_e;
    rst = 1'b1; hold_i = 1'b0; dbus_ack_i = 1'b0; dbus_rdata_i = 32'hFFFF_FFFF;
    aluop_i = EXE_LOAD_OP; alufun3_i = F3_LW; mem_addr_i = 32'h40; reg2_i = 32'h5A5A_5A5A;
    wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h9999;
    repeat (2) @(posedge clk);
    @(negedge clk);
    be_e = '{32'h0, 4'h0, 1'b0, 32'h0};
    exp_bus_q.push_back(be_e);
    be_e = exp_bus_q.pop_front();
    vectors++;
    if (dbus_req_o !== 1'b0 || dbus_we_o !== be_e.we || dbus_addr_o !== be_e.addr ||
        dbus_be_o !== be_e.be || dbus_wdata_o !== be_e.wdata || misalign_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bus: req=%b we=%b addr=%h be=%b wdata=%h mis=%b, want all zero",
               dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, misalign_o);
    end
    vectors++;
    if (wd_o !== 5'd0 || wreg_o !== 1'b0 || wdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_wb: wd=%0d wreg=%b wdata=%h, want 0/0/0", wd_o, wreg_o, wdata_o);
    end
    set_nop(); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    exp_res_q.push_back('{32'h1234, 1'b1, 1'b0, 1'b1, 0});
    run_mem(EXE_ADD_OP, 3'b000, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 32'h0, 32'h0, 0);
    begin
      res_exp_t re_e = exp_res_q.pop_front();
      vectors++;
      if (obs_timeout !== 1'b0 || obs_stall !== re_e.stall || obs_res_req !== 1'b0 || obs_n !== 0) begin
        miscompares++;
        $display("FAIL passthru_stall: stall=%0d req=%b reqs=%0d, want %0d/0/0", obs_stall, obs_res_req, obs_n, re_e.stall);
      end
      vectors++;
      if (obs_wd !== 5'd5 || obs_wreg !== re_e.wreg || obs_wdata_o !== re_e.wdata) begin
        miscompares++;
        $display("FAIL passthru_data: wd=%0d wreg=%b wdata=%h, want 5/%b/%h", obs_wd, obs_wreg, obs_wdata_o, re_e.wreg, re_e.wdata);
      end
    end
  endtask

  task automatic test_mem_table();
    tbl_t tbl[8];
    bus_exp_t be_e;
    res_exp_t re_e;
    tbl[0] = '{EXE_LOAD_OP,  F3_LB,  32'h103, 32'h0,         0, 32'h80FF_FF7F, 1, 32'h100, 4'b1000, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b1, 1'b1, 2};
    tbl[1] = '{EXE_STORE_OP, F3_SH,  32'h202, 32'hABCD_5678, 3, 32'h0,         1, 32'h200, 4'b1100, 1'b1, 32'h5678_5678, 32'h0,         1'b0, 1'b0, 5};
    tbl[2] = '{EXE_LOAD_OP,  F3_LH,  32'h202, 32'h0,         1, 32'h8001_1234, 1, 32'h200, 4'b1100, 1'b0, 32'h0,         32'hFFFF_8001, 1'b1, 1'b1, 3};
    tbl[3] = '{EXE_LOAD_OP,  F3_LHU, 32'h202, 32'h0,         0, 32'h8001_1234, 1, 32'h200, 4'b1100, 1'b0, 32'h0,         32'h0000_8001, 1'b1, 1'b1, 2};
    tbl[4] = '{EXE_LOAD_OP,  F3_LW,  32'h300, 32'h0,         2, 32'hCAFE_F00D, 1, 32'h300, 4'b1111, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b1, 4};
    tbl[5] = '{EXE_STORE_OP, F3_SB,  32'h101, 32'h1234_56A5, 0, 32'h0,         1, 32'h100, 4'b0010, 1'b1, 32'hA5A5_A5A5, 32'h0,         1'b0, 1'b0, 2};
    tbl[6] = '{EXE_LOAD_OP,  3'b011, 32'h100, 32'h0,         0, 32'h1111_1111, 0, 32'h0,   4'b0000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1};
    tbl[7] = '{EXE_STORE_OP, 3'b100, 32'h100, 32'h7777_7777, 0, 32'h0,         0, 32'h0,   4'b0000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1};
    for (int t = 0; t < 8; t++) begin
      if (tbl[t].nbus > 0) exp_bus_q.push_back('{tbl[t].baddr, tbl[t].be, tbl[t].we, tbl[t].bwd});
      exp_res_q.push_back('{tbl[t].rwd, tbl[t].rwreg, 1'b0, tbl[t].chk, tbl[t].stall});
      run_mem(tbl[t].op, tbl[t].f3, tbl[t].addr, tbl[t].reg2, 5'd9, 1'b1, 32'hBAD0_0000,
              tbl[t].waits, tbl[t].rd, 32'h0, 0);
      vectors++;
      if (obs_timeout !== 1'b0 || obs_n !== exp_bus_q.size()) begin
        miscompares++;
        $display("FAIL tbl%0d_reqs: timeout=%b reqs=%0d, want 0/%0d", t, obs_timeout, obs_n, exp_bus_q.size());
      end
      for (int i = 0; exp_bus_q.size() > 0; i++) begin
        be_e = exp_bus_q.pop_front();
        vectors++;
        if (obs_addr[i] !== be_e.addr || obs_be[i] !== be_e.be || obs_we[i] !== be_e.we ||
            (be_e.we && obs_wdata[i] !== be_e.wdata)) begin
          miscompares++;
          $display("FAIL tbl%0d_bus: addr=%h be=%b we=%b wdata=%h, want %h/%b/%b/%h", t,
                   obs_addr[i], obs_be[i], obs_we[i], obs_wdata[i], be_e.addr, be_e.be, be_e.we, be_e.wdata);
        end
      end
      re_e = exp_res_q.pop_front();
      vectors++;
      if (obs_stall !== re_e.stall || obs_wreg !== re_e.wreg || obs_misal !== re_e.misal ||
          (re_e.chk_wd && obs_wdata_o !== re_e.wdata)) begin
        miscompares++;
        $display("FAIL tbl%0d_res: stall=%0d wreg=%b mis=%b wdata=%h, want %0d/%b/%b/%h", t,
                 obs_stall, obs_wreg, obs_misal, obs_wdata_o, re_e.stall, re_e.wreg, re_e.misal, re_e.wdata);
      end
    end
  endtask

  task automatic test_misaligned();
    bus_exp_t be_e;
    res_exp_t re_e;
    for (int k = 0; k < 2; k++) begin
`ifdef MISALIGN_SPLIT_EN
      if (k == 0) begin
        exp_bus_q.push_back('{32'h100, 4'b1110, 1'b0, 32'h0});
        exp_bus_q.push_back('{32'h104, 4'b0001, 1'b0, 32'h0});
        exp_res_q.push_back('{32'h5544_3322, 1'b1, 1'b0, 1'b1, 3});
      end else begin
        exp_bus_q.push_back('{32'h200, 4'b0110, 1'b0, 32'h0});
        exp_res_q.push_back('{32'hFFFF_BEEF, 1'b1, 1'b0, 1'b1, 2});
      end
`else
      exp_res_q.push_back('{32'h0, 1'b0, 1'b1, 1'b1, 1});
`endif
      if (k == 0)
        run_mem(EXE_LOAD_OP, F3_LW, 32'h101, 32'h0, 5'd3, 1'b1, 32'h0, 0, 32'h4433_2211, 32'h8877_6655, 0);
      else
        run_mem(EXE_LOAD_OP, F3_LH, 32'h201, 32'h0, 5'd3, 1'b1, 32'h0, 0, 32'h00BE_EF00, 32'h0, 0);
      vectors++;
      if (obs_timeout !== 1'b0 || obs_n !== exp_bus_q.size()) begin
        miscompares++;
        $display("FAIL mis%0d_reqs: timeout=%b reqs=%0d, want 0/%0d", k, obs_timeout, obs_n, exp_bus_q.size());
      end
      for (int i = 0; exp_bus_q.size() > 0; i++) begin
        be_e = exp_bus_q.pop_front();
        vectors++;
        if (obs_addr[i] !== be_e.addr || obs_be[i] !== be_e.be || obs_we[i] !== be_e.we) begin
          miscompares++;
          $display("FAIL mis%0d_bus%0d: addr=%h be=%b we=%b, want %h/%b/%b", k, i,
                   obs_addr[i], obs_be[i], obs_we[i], be_e.addr, be_e.be, be_e.we);
        end
      end
      re_e = exp_res_q.pop_front();
      vectors++;
      if (obs_stall !== re_e.stall || obs_wreg !== re_e.wreg || obs_misal !== re_e.misal ||
          obs_wdata_o !== re_e.wdata) begin
        miscompares++;
        $display("FAIL mis%0d_res: stall=%0d wreg=%b mis=%b wdata=%h, want %0d/%b/%b/%h", k,
                 obs_stall, obs_wreg, obs_misal, obs_wdata_o, re_e.stall, re_e.wreg, re_e.misal, re_e.wdata);
      end
      @(negedge clk);
      vectors++;
      if (misalign_o !== 1'b0) begin
        miscompares++;
        $display("FAIL mis%0d_pulse: misalign_o=%b one cycle after DONE, want 0", k, misalign_o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_in_bus();
    bit seen = 1'b0;
    aluop_i = EXE_LOAD_OP; alufun3_i = F3_LW; mem_addr_i = 32'h400; wd_i = 5'd4; wreg_i = 1'b1;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      if (dbus_req_o) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rstbus_req: dbus_req_o never rose, want 1");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (dbus_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rstbus_drop: dbus_req_o=%b after reset edge, want 0", dbus_req_o);
    end
    set_nop(); rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (stallreq_o !== 1'b0 || dbus_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rstbus_idle_alu: stallreq=%b req=%b, want 0/0", stallreq_o, dbus_req_o);
    end
    aluop_i = EXE_STORE_OP; alufun3_i = F3_SW; mem_addr_i = 32'h408;
    #1;
    vectors++;
    if (stallreq_o !== 1'b1 || dbus_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rstbus_idle_mem: stallreq=%b req=%b, want 1/0", stallreq_o, dbus_req_o);
    end
    set_nop();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bus_exp_t be_e;
    res_exp_t re_e;
    exp_bus_q.push_back('{32'h000, 4'b0010, 1'b0, 32'h0});
    exp_res_q.push_back('{32'h0000_009A, 1'b1, 1'b0, 1'b1, 2});
    exp_bus_q.push_back('{32'h008, 4'b1111, 1'b1, 32'hDEAD_BEEF});
    exp_res_q.push_back('{32'h0, 1'b0, 1'b0, 1'b0, 2});
    for (int k = 0; k < 2; k++) begin
      if (k == 0)
        run_mem(EXE_LOAD_OP, F3_LBU, 32'h001, 32'h0, 5'd6, 1'b1, 32'h0, 0, 32'h0000_9A00, 32'h0, 2);
      else
        run_mem(EXE_STORE_OP, F3_SW, 32'h008, 32'hDEAD_BEEF, 5'd6, 1'b1, 32'h0, 0, 32'h0, 32'h0, 0);
      be_e = exp_bus_q.pop_front();
      vectors++;
      if (obs_timeout !== 1'b0 || obs_n !== 1 || obs_addr[0] !== be_e.addr || obs_be[0] !== be_e.be ||
          obs_we[0] !== be_e.we || (be_e.we && obs_wdata[0] !== be_e.wdata)) begin
        miscompares++;
        $display("FAIL b2b%0d_bus: reqs=%0d addr=%h be=%b we=%b wdata=%h, want 1/%h/%b/%b/%h", k, obs_n,
                 obs_addr[0], obs_be[0], obs_we[0], obs_wdata[0], be_e.addr, be_e.be, be_e.we, be_e.wdata);
      end
      re_e = exp_res_q.pop_front();
      vectors++;
      if (obs_stall !== re_e.stall || obs_wreg !== re_e.wreg || obs_held_ok !== 1'b1 ||
          (re_e.chk_wd && obs_wdata_o !== re_e.wdata)) begin
        miscompares++;
        $display("FAIL b2b%0d_res: stall=%0d wreg=%b held=%b wdata=%h, want %0d/%b/1/%h", k,
                 obs_stall, obs_wreg, obs_held_ok, obs_wdata_o, re_e.stall, re_e.wreg, re_e.wdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_mem_table();
    test_misaligned();
    test_rst_in_bus();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
